// File: rtl/shreg_pkg.sv
// Shared types and sizing helpers for the symbol shift serializer.
// Symbol count grows by one when SHREG_PARITY_EN adds the trailing parity step.
package shreg_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } shreg_state_e;

  function automatic int unsigned nsym(input int unsigned data_w, input int unsigned sym_bits,
                                       input bit parity);
    return data_w / sym_bits + (parity ? 1 : 0);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_down_counter.sv
// Loadable down-counter that holds at zero; clear beats load beats decrement.
// Reports both the count and a zero flag.
module step_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/symbol_shift_serializer.sv
// Parallel-in/serial-out symbol serializer paced by an external step strobe.
// Define SHREG_PARITY_EN to append an even-parity symbol after each word.
module symbol_shift_serializer
  import shreg_pkg::*;
#(
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned SYM_BITS  = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                step_en,
  input  logic                flush,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic                busy,
  output logic                done
);

`ifdef SHREG_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif
  localparam int unsigned    NSym    = nsym(DATA_W, SYM_BITS, ParityEn);
  localparam int unsigned    CntW    = cnt_width(NSym);
  localparam logic [CntW-1:0] CntLoad = CntW'(NSym - 1);

  if ((DATA_W % SYM_BITS) != 0) begin : g_bad_width
    $error("DATA_W must be an integer multiple of SYM_BITS");
  end

  shreg_state_e        state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                done_q, done_d;
  logic [CntW-1:0]     cnt;
  logic                cnt_zero;
  logic                in_shift, last_step, accept, shift_step, cnt_clr;
  logic [SYM_BITS-1:0] data_sym;

  assign in_shift   = (state_q == StShift);
  assign last_step  = in_shift && step_en && cnt_zero;
  assign accept     = in_valid && in_ready && !flush;
  assign shift_step = in_shift && step_en && !cnt_zero;
  assign cnt_clr    = flush || (last_step && !accept);

  step_down_counter #(
    .Width(CntW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .load    (accept),
    .load_val(CntLoad),
    .en      (shift_step),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = StShift;
    end else if (last_step) begin
      state_d = StIdle;
    end
  end

  // Register empties on the last step so IDLE always presents a zero symbol.
  always_comb begin
    shreg_d = shreg_q;
    done_d  = last_step && !flush;
    if (flush) begin
      shreg_d = '0;
    end else if (accept) begin
      shreg_d = in_data;
    end else if (last_step) begin
      shreg_d = '0;
    end else if (shift_step) begin
      shreg_d = (MSB_FIRST != 0) ? (shreg_q << SYM_BITS) : (shreg_q >> SYM_BITS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  if (MSB_FIRST != 0) begin : g_msb
    assign data_sym = shreg_q[DATA_W-1 -: SYM_BITS];
  end else begin : g_lsb
    assign data_sym = shreg_q[SYM_BITS-1:0];
  end

`ifdef SHREG_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (flush) begin
      par_d = 1'b0;
    end else if (accept) begin
      par_d = ^in_data;
    end else if (last_step) begin
      par_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    in_ready  = !in_shift || last_step;
    sym_valid = in_shift;
    busy      = in_shift;
    done      = done_q;
    sym_out   = data_sym;
`ifdef SHREG_PARITY_EN
    // Count zero while shifting is the parity step; data bits are already gone.
    if (in_shift && cnt_zero) begin
      sym_out = SYM_BITS'(par_q);
    end
`endif
  end

  a_idle_count_zero : assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle) |-> (cnt == '0));

endmodule

// File: tb/tb_symbol_shift_serializer.sv
// Self-checking bench: accepted words feed a scoreboard of expected symbols that a
// negedge monitor compares against sym_out, sym_valid, busy, in_ready and done.
module tb_symbol_shift_serializer;

  localparam int unsigned DATA_W    = 9;
  localparam int unsigned SYM_BITS  = 1;
  localparam int unsigned MSB_FIRST = 1;
  localparam int unsigned ND        = DATA_W / SYM_BITS;
`ifdef SHREG_PARITY_EN
  localparam int unsigned NS = ND + 1;
`else
  localparam int unsigned NS = ND;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DATA_W-1:0]   in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                step_en = 1'b0;
  logic                flush = 1'b0;
  logic [SYM_BITS-1:0] sym_out;
  logic                sym_valid;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] pend[$];  // words accepted, not yet visible on the outputs
  int                cur[$];   // remaining expected symbols of the word in flight
  bit                exp_done = 1'b0;
  bit                prev_step = 1'b0;
  bit                prev_flush = 1'b0;

  symbol_shift_serializer #(
    .DATA_W   (DATA_W),
    .SYM_BITS (SYM_BITS),
    .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .step_en  (step_en),
    .flush    (flush),
    .sym_out  (sym_out),
    .sym_valid(sym_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Symbol idx of word w, straight from the bit-ordering rules.
  function automatic int exp_sym(input logic [DATA_W-1:0] w, input int idx);
    logic [DATA_W-1:0] t;
    if (idx >= int'(ND)) return int'(^w);
    if (MSB_FIRST != 0) t = w >> (DATA_W - (idx + 1) * SYM_BITS);
    else t = w >> (idx * SYM_BITS);
    return int'(t) & ((1 << SYM_BITS) - 1);
  endfunction

  // One clock of stimulus; records the word if the handshake completes.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic s, input logic f,
                     output bit acc);
    @(posedge clk);
    #2;
    in_valid = v;
    in_data  = d;
    step_en  = s;
    flush    = f;
    #4;
    acc = !rst && v && in_ready && !f;
    if (acc) pend.push_back(d);
  endtask

  task automatic idle_cycles(input int n, input logic s);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, s, 1'b0, acc);
  endtask

  // Offer a word and hold it until taken, stepping every 'period' cycles.
  task automatic send(input logic [DATA_W-1:0] w, input int period, inout int k);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      cyc(1'b1, w, (k % period) == period - 1, 1'b0, acc);
      k++;
    end
    chk("send_accepted", int'(acc), 1);
  endtask

  // Monitor: advance the model by last cycle's events, then compare.
  initial begin
    logic [DATA_W-1:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur.delete();
        pend.delete();
        exp_done   = 1'b0;
        prev_step  = 1'b0;
        prev_flush = 1'b0;
      end else begin
        exp_done = 1'b0;
        if (prev_flush) begin
          cur.delete();
        end else if (prev_step && cur.size() > 0) begin
          void'(cur.pop_front());
          if (cur.size() == 0) exp_done = 1'b1;
        end
        while (pend.size() > 0) begin
          w = pend.pop_front();
          for (int i = 0; i < int'(NS); i++) cur.push_back(exp_sym(w, i));
        end
      end
      chk("sym_valid", int'(sym_valid), int'(cur.size() > 0));
      chk("busy", int'(busy), int'(cur.size() > 0));
      chk("sym_out", int'(sym_out), (cur.size() > 0) ? cur[0] : 0);
      chk("done", int'(done), int'(exp_done));
      chk("in_ready", int'(in_ready),
          int'((cur.size() == 0) || (cur.size() == 1 && step_en)));
      prev_step  = step_en;
      prev_flush = flush;
    end
  end

  initial begin
    bit acc;
    bit v_hold;
    logic v;
    logic [DATA_W-1:0] d;
    int k;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Steps in IDLE must not disturb anything.
    idle_cycles(4, 1'b1);

    // Single word, then one step per cycle with gaps.
    cyc(1'b1, 9'h1A5, 1'b0, 1'b0, acc);
    for (int i = 0; i < 2 * int'(NS); i++) cyc(1'b0, '0, i[0], 1'b0, acc);
    idle_cycles(3, 1'b0);

    // Back-to-back words with in_valid held, step every 4th cycle.
    k = 0;
    send(9'h1A5, 4, k);
    send(9'h0FF, 4, k);
    for (int i = 0; i < 4 * int'(NS) + 8; i++) begin
      cyc(1'b0, '0, (k % 4) == 3, 1'b0, acc);
      k++;
    end

    // Flush after the fourth step, with a competing word offered.
    cyc(1'b1, 9'h133, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b1, 9'h0AA, 1'b1, 1'b1, acc);
    chk("flush_blocks_load", int'(acc), 0);
    idle_cycles(2, 1'b1);
    cyc(1'b1, 9'h0F0, 1'b0, 1'b0, acc);
    idle_cycles(int'(NS) + 2, 1'b1);

    // Randomised traffic with held-valid handshakes and occasional flush.
    v_hold = 1'b0;
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!v_hold) begin
        v = ($urandom_range(0, 2) != 0);
        d = DATA_W'($urandom);
      end
      cyc(v, d, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0, acc);
      v_hold = v && !acc;
    end
    idle_cycles(int'(NS) + 4, 1'b1);

    // Asynchronous reset in the middle of a word.
    cyc(1'b1, 9'h1A5, 1'b0, 1'b0, acc);
    idle_cycles(3, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sym_out", int'(sym_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    step_en  = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle_cycles(4, 1'b1);
    cyc(1'b1, 9'h0C3, 1'b0, 1'b0, acc);
    idle_cycles(int'(NS) + 3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/symbol_shift_serializer.md
Name: symbol_shift_serializer

Overview:
- Parametrised parallel-in/serial-out shift register for the digital modulation datapath.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits it SYM_BITS bits per step, MSB-first or LSB-first, paced by an external baud/step strobe.
- Sits between the data source and the symbol mapper (BPSK/QPSK/8-PSK). Supports back-to-back words with no idle step, a synchronous flush, and a completion pulse.

Parameters:
- DATA_W, 9: parallel word width. Must be an integer multiple of SYM_BITS (elaboration-time check).
- SYM_BITS, 1: bits emitted per step. 1 = BPSK, 2 = QPSK, 3 = 8-PSK.
- MSB_FIRST, 1: 1 emits from the top bits downward; 0 emits from the bottom bits upward.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_data  input  DATA_W  parallel word to serialise
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- step_en  input  1  one-cycle baud strobe that advances one symbol
- flush  input  1  synchronous abort to idle
- sym_out  output  SYM_BITS  current symbol
- sym_valid  output  1  sym_out holds a live symbol
- busy  output  1  word in progress
- done  output  1  one-cycle pulse after the last symbol of a word is consumed

Interface: reset rst, asynchronous, active-high; clock clk. All other state is updated on the posedge of clk.

Behaviour:
- NSYM = DATA_W/SYM_BITS symbols per word. Internal count width is clog2(NSYM), minimum 1.
- Reset values: state IDLE, shift register 0, count 0, sym_out 0, sym_valid 0, busy 0, done 0, in_ready 1.
- States:
  - IDLE: in_ready = 1; step_en is ignored.
  - SHIFT: sym_valid = 1, busy = 1.
- IDLE -> SHIFT: on in_valid && in_ready at a clock edge.
  - Load the shift register with in_data and set count = NSYM-1.
  - The first symbol appears on sym_out in the next cycle (load-to-symbol latency is 1 cycle).
- sym_out is combinational from the register: top SYM_BITS bits if MSB_FIRST, otherwise bottom SYM_BITS bits.
- SHIFT with step_en and count > 0:
  - Shift by SYM_BITS toward the emitting end, filling with zeros, and decrement count.
  - Steps are not counted without step_en.
- SHIFT with step_en and count == 0 (last symbol consumed):
  - done = 1 in the next cycle, for exactly one cycle.
  - in_ready = 1 combinationally in this cycle.
  - If in_valid is also high: load the new word, set count = NSYM-1, stay in SHIFT. There is no gap symbol.
  - Otherwise go to IDLE and clear the register to 0.
- In all other SHIFT cycles in_ready = 0. in_valid is held off and in_data is ignored.
- flush: takes priority over load and shift.
  - Next state is IDLE; register and count are cleared; done is not asserted.
  - A word offered in the same cycle as flush is not accepted, even though in_ready may read 1.
- Reset mid-word: the word is discarded immediately (asynchronous); no done pulse.
- NSYM == 1 (DATA_W == SYM_BITS): each accepted word lasts exactly one step, and done follows that step.

Optional Feature:
- Macro: SHREG_PARITY_EN.
- Defined:
  - NSYM becomes DATA_W/SYM_BITS + 1.
  - After the last data symbol, one extra parity step is emitted. sym_out[0] = even parity (XOR) of the loaded word, and the other sym_out bits are 0.
  - Parity is captured at load time.
  - done and in_ready key off the parity step instead of the last data symbol.
- Undefined: no parity step and no parity register; behaviour is exactly as above.

Decomposition:
- Package shreg_pkg holds:
  - the state enum (IDLE, SHIFT);
  - function nsym(DATA_W, SYM_BITS, parity) returning the symbol count;
  - a count-width helper based on clog2.
- One sub-module, step_down_counter: loadable down-counter with enable, synchronous clear and asynchronous reset. It outputs the count and a zero flag, and is reused for count.
- Shifting and symbol selection stay in the top module.

Test Plan:
- DATA_W=9, SYM_BITS=1, MSB_FIRST=1:
  - Stimulus: load 9'h1A5, then 9 step_en pulses.
  - Response: sym_out sequence 1,1,0,1,0,0,1,0,1; done pulses once, 1 cycle after the 9th step; then IDLE with in_ready = 1.
- SYM_BITS=3, MSB_FIRST=1:
  - Stimulus: load 9'h1A5 (octal 645).
  - Response: symbols 6,4,5. With MSB_FIRST=0 the symbols are 5,4,6.
- Back-to-back:
  - Stimulus: keep in_valid high with 9'h1A5 then 9'h0FF, step_en every 4th cycle.
  - Response: 18 consecutive symbols with no idle step; in_ready is high only in the last-step cycle of each word; 2 done pulses.
- Flush:
  - Stimulus: assert flush after the 4th step.
  - Response: IDLE next cycle; sym_valid = 0; no done pulse; the next word starts again at its first symbol.
- Async reset mid-word:
  - Response: all outputs take their reset values without waiting for a clock edge.
  - Also check that step_en in IDLE changes nothing.
- SHREG_PARITY_EN, SYM_BITS=1:
  - Stimulus: load 9'h1A5 (five ones).
  - Response: 10 symbols, the 10th = 1; done follows the 10th step.
